wb_stage: RTL

Writeback stage of the NPC core: consumes retired instructions from the MEM/WB valid/ready channel and drives the register-file write port. It detects `ebreak`/illegal termination and exposes a registered halt status with exit code, plus 64-bit cycle/retire counters. The simulation top and the difftest harness read these status outputs instead of probing regfile internals.

---
 rtl/npc_pkg.sv | 32 +++
 rtl/wb_perf_cnt.sv | 56 +++++
 rtl/wb_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// -----------------------------------------------------------------------------
// npc_pkg
// Shared definitions for the NPC core pipeline back end.
//   XLEN          default datapath width
//   REG_A0        architectural index of a0 (x10), carries the exit code
//   wb_state_e    writeback stage control states
//   halt_cause_e  reason the core stopped
//   halt_good_f   helper deciding whether a halt counts as a clean exit
// -----------------------------------------------------------------------------
package npc_pkg;

    localparam int XLEN   = 32;
    localparam int REG_A0 = 10;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HALT_PEND = 2'd1,
        HALTED    = 2'd2
    } wb_state_e;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        EBREAK  = 2'd1,
        ILLEGAL = 2'd2
    } halt_cause_e;

    // A halt is "good" only when ebreak stopped the core with a0 == 0.
    function automatic logic halt_good_f(input halt_cause_e cause, input logic code_is_zero);
        return (cause == EBREAK) && code_is_zero;
    endfunction

endpackage : npc_pkg

// File: rtl/wb_perf_cnt.sv
// -----------------------------------------------------------------------------
// wb_perf_cnt
// Pair of free-running 64-bit performance counters (wrap modulo 2^64).
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-high reset, clears both counters
//   inc_cycle_i    in   count this cycle
//   inc_retire_i   in   count one retired instruction
//   cycle_cnt_o    out  registered cycle count
//   retire_cnt_o   out  registered retire count
// -----------------------------------------------------------------------------
module wb_perf_cnt (
    input  logic        clock,
    input  logic        reset,
    input  logic        inc_cycle_i,
    input  logic        inc_retire_i,
    output logic [63:0] cycle_cnt_o,
    output logic [63:0] retire_cnt_o
);

    logic [63:0] cycle_q;
    logic [63:0] cycle_d;
    logic [63:0] retire_q;
    logic [63:0] retire_d;

    // Next-count computation for both counters.
    always_comb begin
        cycle_d  = cycle_q;
        retire_d = retire_q;
        if (inc_cycle_i) begin
            cycle_d = cycle_q + 64'd1;
        end else begin
            cycle_d = cycle_q;
        end
        if (inc_retire_i) begin
            retire_d = retire_q + 64'd1;
        end else begin
            retire_d = retire_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cycle_q  <= 64'd0;
            retire_q <= 64'd0;
        end else begin
            cycle_q  <= cycle_d;
            retire_q <= retire_d;
        end
    end

    assign cycle_cnt_o  = cycle_q;
    assign retire_cnt_o = retire_q;

endmodule : wb_perf_cnt

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Writeback stage of the NPC core. Accepts retired instructions from the
// MEM/WB valid/ready channel, drives the register-file write port, detects
// ebreak / illegal termination and publishes a registered halt status plus
// 64-bit cycle and retire counters.
//
// Parameters: XLEN (datapath width), RA_W (register address width)
// Ports:
//   clock, reset                 clock and asynchronous active-high reset
//   io_mem_wb_valid/ready        upstream handshake (ready only in RUN)
//   io_mem_wb_bits_*             pc, rd, wdata, wen, ebreak, illegal
//   rf_wen/rf_waddr/rf_wdata     registered register-file write, 1 cycle late
//   halt/halt_good/halt_code     registered halt status
//   cycle_cnt/retire_cnt         64-bit performance counters
//
// Optional feature, macro WB_COMMIT_TRACE_EN: adds commit_valid, commit_pc,
// commit_rd, commit_wdata and commit_wen, registered like rf_*, pulsing once
// per accepted instruction (ebreak/illegal included).
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int XLEN = npc_pkg::XLEN,
    parameter int RA_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_mem_wb_valid,
    output logic            io_mem_wb_ready,
    input  logic [XLEN-1:0] io_mem_wb_bits_pc,
    input  logic [RA_W-1:0] io_mem_wb_bits_rd,
    input  logic [XLEN-1:0] io_mem_wb_bits_wdata,
    input  logic            io_mem_wb_bits_wen,
    input  logic            io_mem_wb_bits_ebreak,
    input  logic            io_mem_wb_bits_illegal,
    output logic            rf_wen,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            halt,
    output logic            halt_good,
    output logic [XLEN-1:0] halt_code,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     retire_cnt
`ifdef WB_COMMIT_TRACE_EN
    ,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [RA_W-1:0] commit_rd,
    output logic [XLEN-1:0] commit_wdata,
    output logic            commit_wen
`endif
);

    import npc_pkg::*;

    localparam logic [RA_W-1:0] A0_ADDR = RA_W'(REG_A0);

    wb_state_e       state_q;
    wb_state_e       state_d;
    halt_cause_e     cause_q;
    halt_cause_e     cause_d;
    logic [XLEN-1:0] code_q;
    logic [XLEN-1:0] code_d;
    logic [XLEN-1:0] a0_q;
    logic [XLEN-1:0] a0_d;
    logic            ready_q;
    logic            ready_d;
    logic            rf_wen_q;
    logic            rf_wen_d;
    logic [RA_W-1:0] rf_waddr_q;
    logic [RA_W-1:0] rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q;
    logic [XLEN-1:0] rf_wdata_d;
    logic            halt_q;
    logic            halt_d;
    logic            halt_good_q;
    logic            halt_good_d;
    logic [XLEN-1:0] halt_code_q;
    logic [XLEN-1:0] halt_code_d;

    logic accept_s;
    logic term_s;
    logic write_s;

    assign accept_s = io_mem_wb_valid && ready_q;
    assign term_s   = accept_s && (io_mem_wb_bits_ebreak || io_mem_wb_bits_illegal);
    // Terminating instructions never write, whatever their wen says; x0 is never written.
    assign write_s  = accept_s && !term_s && io_mem_wb_bits_wen
                      && (io_mem_wb_bits_rd != {RA_W{1'b0}});

    // Control FSM next state, halt cause/code latch and halt status update.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        code_d      = code_q;
        halt_d      = halt_q;
        halt_good_d = halt_good_q;
        halt_code_d = halt_code_q;
        case (state_q)
            RUN: begin
                if (term_s) begin
                    state_d = HALT_PEND;
                    // ebreak takes priority when both flags are raised.
                    if (io_mem_wb_bits_ebreak) begin
                        cause_d = EBREAK;
                        code_d  = a0_q;
                    end else begin
                        cause_d = ILLEGAL;
                        code_d  = io_mem_wb_bits_pc;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            HALT_PEND: begin
                state_d     = HALTED;
                halt_d      = 1'b1;
                halt_code_d = code_q;
                halt_good_d = halt_good_f(cause_q, code_q == {XLEN{1'b0}});
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        ready_d = (state_d == RUN);
    end

    // Register-file write port and a0 shadow next values.
    always_comb begin
        a0_d       = a0_q;
        rf_wen_d   = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (write_s) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = io_mem_wb_bits_rd;
            rf_wdata_d = io_mem_wb_bits_wdata;
            if (io_mem_wb_bits_rd == A0_ADDR) begin
                a0_d = io_mem_wb_bits_wdata;
            end else begin
                a0_d = a0_q;
            end
        end else begin
            rf_wen_d = 1'b0;
        end
    end

    // Control and status registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            ready_q     <= 1'b1;
            cause_q     <= NONE;
            code_q      <= {XLEN{1'b0}};
            halt_q      <= 1'b0;
            halt_good_q <= 1'b0;
            halt_code_q <= {XLEN{1'b0}};
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            cause_q     <= cause_d;
            code_q      <= code_d;
            halt_q      <= halt_d;
            halt_good_q <= halt_good_d;
            halt_code_q <= halt_code_d;
        end
    end

    // Write-port and a0 shadow registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a0_q       <= {XLEN{1'b0}};
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= {RA_W{1'b0}};
            rf_wdata_q <= {XLEN{1'b0}};
        end else begin
            a0_q       <= a0_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    wb_perf_cnt u_perf_cnt (
        .clock        (clock),
        .reset        (reset),
        .inc_cycle_i  (state_q != HALTED),
        .inc_retire_i (accept_s),
        .cycle_cnt_o  (cycle_cnt),
        .retire_cnt_o (retire_cnt)
    );

    assign io_mem_wb_ready = ready_q;
    assign rf_wen          = rf_wen_q;
    assign rf_waddr        = rf_waddr_q;
    assign rf_wdata        = rf_wdata_q;
    assign halt            = halt_q;
    assign halt_good       = halt_good_q;
    assign halt_code       = halt_code_q;

`ifdef WB_COMMIT_TRACE_EN
    logic            commit_valid_q;
    logic [XLEN-1:0] commit_pc_q;
    logic [RA_W-1:0] commit_rd_q;
    logic [XLEN-1:0] commit_wdata_q;
    logic            commit_wen_q;

    // Commit trace registers; commit_wen reports the write actually performed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            commit_valid_q <= 1'b0;
            commit_pc_q    <= {XLEN{1'b0}};
            commit_rd_q    <= {RA_W{1'b0}};
            commit_wdata_q <= {XLEN{1'b0}};
            commit_wen_q   <= 1'b0;
        end else begin
            commit_valid_q <= accept_s;
            if (accept_s) begin
                commit_pc_q    <= io_mem_wb_bits_pc;
                commit_rd_q    <= io_mem_wb_bits_rd;
                commit_wdata_q <= io_mem_wb_bits_wdata;
                commit_wen_q   <= write_s;
            end else begin
                commit_pc_q    <= commit_pc_q;
                commit_rd_q    <= commit_rd_q;
                commit_wdata_q <= commit_wdata_q;
                commit_wen_q   <= commit_wen_q;
            end
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;
    assign commit_rd    = commit_rd_q;
    assign commit_wdata = commit_wdata_q;
    assign commit_wen   = commit_wen_q;
`endif

endmodule : wb_stage
